// File: rtl/table_writer.sv
// Aho-Corasick goto/failure table loader: clears both RAMs after START, then
// turns each accepted valid/ready entry into a single-cycle registered RAM write.
module table_writer #(
  parameter logic [7:0]  FAIL_CODE  = 8'hFF,
  parameter int unsigned NUM_STATES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_TYPE,
  input  logic [7:0]  IN_STATE,
  input  logic [3:0]  IN_CHARA,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_LAST,
  output logic        WE_G,
  output logic [11:0] ADDR_G,
  output logic [7:0]  DATA_G,
  output logic        WE_F,
  output logic [11:0] ADDR_F,
  output logic [7:0]  DATA_F,
  output logic        BUSY,
  output logic        DONE,
  output logic [12:0] ENTRY_CNT,
  output logic        ERR
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic        we_g_q, we_g_d;
  logic [11:0] addr_g_q, addr_g_d;
  logic [7:0]  data_g_q, data_g_d;
  logic        we_f_q, we_f_d;
  logic [11:0] addr_f_q, addr_f_d;
  logic [7:0]  data_f_q, data_f_d;
  logic [12:0] entry_cnt_q, entry_cnt_d;
  logic        err_q, err_d;

  logic        clr_issue;
  logic [11:0] clr_addr;
  logic        accept;
  logic        in_range;

  assign accept   = (state_q == S_LOAD) && IN_VALID;
  assign in_range = ({24'd0, IN_STATE} < NUM_STATES) && ({24'd0, IN_DATA} < NUM_STATES);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    we_g_d      = 1'b0;
    addr_g_d    = addr_g_q;
    data_g_d    = data_g_q;
    we_f_d      = 1'b0;
    addr_f_d    = addr_f_q;
    data_f_d    = data_f_q;
    entry_cnt_d = entry_cnt_q;
    err_d       = err_q;
    clr_issue   = 1'b0;
    clr_addr    = 12'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d     = S_CLEAR;
          clr_issue   = 1'b1;
          clr_addr    = 12'd0;
          entry_cnt_d = 13'd0;
          err_d       = 1'b0;
        end
      end
      S_CLEAR: begin
        // clr_cnt_q is the address of the write currently on the outputs
        if (clr_cnt_q == 12'hFFF) begin
          state_d = S_LOAD;
        end else begin
          clr_issue = 1'b1;
          clr_addr  = clr_cnt_q + 12'd1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (in_range) begin
            if (IN_TYPE) begin
              we_f_d   = 1'b1;
              addr_f_d = {4'b0000, IN_STATE};
              data_f_d = IN_DATA;
            end else begin
              we_g_d   = 1'b1;
              addr_g_d = {IN_STATE, IN_CHARA};
              data_g_d = IN_DATA;
            end
            if (entry_cnt_q != 13'h1FFF) entry_cnt_d = entry_cnt_q + 13'd1;
          end else begin
            err_d = 1'b1;
          end
          if (IN_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_issue) begin
      clr_cnt_d = clr_addr;
      we_g_d    = 1'b1;
      addr_g_d  = clr_addr;
      data_g_d  = (clr_addr[11:4] == 8'd0) ? 8'h00 : FAIL_CODE;
      // The failure table only spans the first 256 addresses
      if (clr_addr[11:8] == 4'd0) begin
        we_f_d   = 1'b1;
        addr_f_d = {4'b0000, clr_addr[7:0]};
        data_f_d = 8'h00;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= 12'd0;
      we_g_q      <= 1'b0;
      addr_g_q    <= 12'd0;
      data_g_q    <= 8'd0;
      we_f_q      <= 1'b0;
      addr_f_q    <= 12'd0;
      data_f_q    <= 8'd0;
      entry_cnt_q <= 13'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      we_g_q      <= we_g_d;
      addr_g_q    <= addr_g_d;
      data_g_q    <= data_g_d;
      we_f_q      <= we_f_d;
      addr_f_q    <= addr_f_d;
      data_f_q    <= data_f_d;
      entry_cnt_q <= entry_cnt_d;
      err_q       <= err_d;
    end
  end

  assign IN_READY  = (state_q == S_LOAD);
  assign BUSY      = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign DONE      = (state_q == S_DONE);
  assign WE_G      = we_g_q;
  assign ADDR_G    = addr_g_q;
  assign DATA_G    = data_g_q;
  assign WE_F      = we_f_q;
  assign ADDR_F    = addr_f_q;
  assign DATA_F    = data_f_q;
  assign ENTRY_CNT = entry_cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_table_writer.sv
// Directed bench for table_writer: clear sweep, vector table in LOAD,
// restart/saturation and asynchronous reset sequences.
module tb_table_writer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_TYPE;
  logic [7:0]  IN_STATE;
  logic [3:0]  IN_CHARA;
  logic [7:0]  IN_DATA;
  logic        IN_LAST;
  logic        WE_G;
  logic [11:0] ADDR_G;
  logic [7:0]  DATA_G;
  logic        WE_F;
  logic [11:0] ADDR_F;
  logic [7:0]  DATA_F;
  logic        BUSY;
  logic        DONE;
  logic [12:0] ENTRY_CNT;
  logic        ERR;

  int n_cmp = 0;
  int n_bad = 0;

  table_writer #(.FAIL_CODE(8'hFF), .NUM_STATES(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_TYPE(IN_TYPE), .IN_STATE(IN_STATE), .IN_CHARA(IN_CHARA), .IN_DATA(IN_DATA),
    .IN_LAST(IN_LAST), .WE_G(WE_G), .ADDR_G(ADDR_G), .DATA_G(DATA_G), .WE_F(WE_F),
    .ADDR_F(ADDR_F), .DATA_F(DATA_F), .BUSY(BUSY), .DONE(DONE), .ENTRY_CNT(ENTRY_CNT),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic        t;
    logic [7:0]  st;
    logic [3:0]  ch;
    logic [7:0]  d;
    logic        last;
    logic        we_g;
    logic [11:0] ag;
    logic [7:0]  dg;
    logic        we_f;
    logic [11:0] af;
    logic [7:0]  df;
    logic [12:0] cnt;
    logic        err;
    logic        rdy;
    logic        dn;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic t, input logic [7:0] st,
                       input logic [3:0] ch, input logic [7:0] d, input logic last);
    IN_VALID = v;
    IN_TYPE  = t;
    IN_STATE = st;
    IN_CHARA = ch;
    IN_DATA  = d;
    IN_LAST  = last;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(IN_READY), 32'd0);
    chk({tag, "_we_g"}, 32'(WE_G), 32'd0);
    chk({tag, "_addr_g"}, 32'(ADDR_G), 32'd0);
    chk({tag, "_data_g"}, 32'(DATA_G), 32'd0);
    chk({tag, "_we_f"}, 32'(WE_F), 32'd0);
    chk({tag, "_addr_f"}, 32'(ADDR_F), 32'd0);
    chk({tag, "_data_f"}, 32'(DATA_F), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_entry_cnt"}, 32'(ENTRY_CNT), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  // Pulses START, then follows the clear sweep until IN_READY rises (bounded).
  task automatic run_clear(input bit poke, output int rdy_cyc, output int gw, output int fw,
                           output int bad, output logic [7:0] g00f, output logic [7:0] g010,
                           output logic [7:0] f0ff, output logic [12:0] cnt1, output logic err1);
    logic [11:0] ea;
    rdy_cyc = -1; gw = 0; fw = 0; bad = 0;
    g00f = 8'hAA; g010 = 8'hAA; f0ff = 8'hAA; cnt1 = 13'h1555; err1 = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      ea = 12'(cyc - 1);
      if (cyc == 1) begin
        cnt1 = ENTRY_CNT;
        err1 = ERR;
      end
      if (IN_READY) begin
        rdy_cyc = cyc;
        break;
      end
      if (BUSY !== 1'b1 || WE_G !== 1'b1) bad++;
      if (WE_G) begin
        gw++;
        if (ADDR_G !== ea) bad++;
        if (DATA_G !== ((ea[11:4] == 8'd0) ? 8'h00 : 8'hFF)) bad++;
        if (ADDR_G == 12'h00F) g00f = DATA_G;
        if (ADDR_G == 12'h010) g010 = DATA_G;
      end
      if (WE_F !== (ea < 12'd256)) bad++;
      if (WE_F) begin
        fw++;
        if (ADDR_F !== {4'b0000, ea[7:0]} || DATA_F !== 8'h00) bad++;
        if (ADDR_F == 12'h0FF) f0ff = DATA_F;
      end
      START = poke && (cyc == 100);
      tick();
    end
    START = 1'b0;
  endtask

  task automatic check_clear(input string tag, input int rdy_cyc, input int gw, input int fw,
                             input int bad, input logic [7:0] g00f, input logic [7:0] g010,
                             input logic [7:0] f0ff);
    chk({tag, "_ready_cycle"}, 32'(rdy_cyc), 32'd4097);
    chk({tag, "_goto_writes"}, 32'(gw), 32'd4096);
    chk({tag, "_fail_writes"}, 32'(fw), 32'd256);
    chk({tag, "_sweep_errors"}, 32'(bad), 32'd0);
    chk({tag, "_goto_00f"}, 32'(g00f), 32'h00);
    chk({tag, "_goto_010"}, 32'(g010), 32'hFF);
    chk({tag, "_fail_0ff"}, 32'(f0ff), 32'h00);
    $display("clear %s: ready at cycle %0d, %0d goto / %0d failure writes", tag, rdy_cyc, gw, fw);
  endtask

  initial begin
    int          rdy_cyc, gw, fw, bad, sat_bad, wait_cyc;
    logic [7:0]  g00f, g010, f0ff;
    logic [12:0] cnt1, exp_cnt;
    logic        err1;

    //         v     t     st     ch    d      last  we_g  ag       dg     we_f  af       df     cnt     err   rdy   dn
    vecs[0] = '{1'b1, 1'b0, 8'h03, 4'hA, 8'h07, 1'b0, 1'b1, 12'h03A, 8'h07, 1'b0, 12'h0FF, 8'h00, 13'd1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 12'h03A, 8'h07, 1'b0, 12'h0FF, 8'h00, 13'd1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h14, 4'h0, 8'h01, 1'b0, 1'b0, 12'h03A, 8'h07, 1'b0, 12'h0FF, 8'h00, 13'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h0F, 4'hF, 8'h0F, 1'b0, 1'b1, 12'h0FF, 8'h0F, 1'b0, 12'h0FF, 8'h00, 13'd2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h02, 4'h0, 8'h10, 1'b0, 1'b0, 12'h0FF, 8'h0F, 1'b0, 12'h0FF, 8'h00, 13'd2, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'h05, 4'hC, 8'h02, 1'b0, 1'b0, 12'h0FF, 8'h0F, 1'b1, 12'h005, 8'h02, 13'd3, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h05, 4'h1, 8'h09, 1'b1, 1'b1, 12'h051, 8'h09, 1'b0, 12'h005, 8'h02, 13'd4, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h01, 4'h1, 8'h01, 1'b0, 1'b0, 12'h051, 8'h09, 1'b0, 12'h005, 8'h02, 13'd4, 1'b1, 1'b0, 1'b1};

    RST = 1'b0;
    START = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #2;
    check_all_zero("reset");
    tick();
    tick();
    RST = 1'b1;
    tick();
    tick();
    check_all_zero("idle");
    $display("reset released, idle checked");

    // First clear with a START poke in the middle, which must be ignored.
    run_clear(1'b1, rdy_cyc, gw, fw, bad, g00f, g010, f0ff, cnt1, err1);
    check_clear("clear1", rdy_cyc, gw, fw, bad, g00f, g010, f0ff);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].t, vecs[i].st, vecs[i].ch, vecs[i].d, vecs[i].last);
      tick();
      chk($sformatf("v%0d_we_g", i), 32'(WE_G), 32'(vecs[i].we_g));
      chk($sformatf("v%0d_addr_g", i), 32'(ADDR_G), 32'(vecs[i].ag));
      chk($sformatf("v%0d_data_g", i), 32'(DATA_G), 32'(vecs[i].dg));
      chk($sformatf("v%0d_we_f", i), 32'(WE_F), 32'(vecs[i].we_f));
      chk($sformatf("v%0d_addr_f", i), 32'(ADDR_F), 32'(vecs[i].af));
      chk($sformatf("v%0d_data_f", i), 32'(DATA_F), 32'(vecs[i].df));
      chk($sformatf("v%0d_entry_cnt", i), 32'(ENTRY_CNT), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_err", i), 32'(ERR), 32'(vecs[i].err));
      chk($sformatf("v%0d_in_ready", i), 32'(IN_READY), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_done", i), 32'(DONE), 32'(vecs[i].dn));
      $display("vec %0d: v=%0b t=%0b st=%0h ch=%0h d=%0h last=%0b -> we_g=%0b ag=%03h we_f=%0b af=%03h cnt=%0d err=%0b",
               i, vecs[i].v, vecs[i].t, vecs[i].st, vecs[i].ch, vecs[i].d, vecs[i].last,
               WE_G, ADDR_G, WE_F, ADDR_F, ENTRY_CNT, ERR);
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);

    // START from DONE restarts the clear and zeroes ENTRY_CNT and ERR.
    run_clear(1'b0, rdy_cyc, gw, fw, bad, g00f, g010, f0ff, cnt1, err1);
    check_clear("clear2", rdy_cyc, gw, fw, bad, g00f, g010, f0ff);
    chk("restart_entry_cnt", 32'(cnt1), 32'd0);
    chk("restart_err", 32'(err1), 32'd0);

    // START during LOAD is ignored; the entry in the same cycle is written.
    START = 1'b1;
    drive(1'b1, 1'b0, 8'h02, 4'h3, 8'h04, 1'b0);
    tick();
    START = 1'b0;
    chk("load_start_we_g", 32'(WE_G), 32'd1);
    chk("load_start_addr_g", 32'(ADDR_G), 32'h023);
    chk("load_start_in_ready", 32'(IN_READY), 32'd1);
    chk("load_start_busy", 32'(BUSY), 32'd1);
    chk("load_start_cnt", 32'(ENTRY_CNT), 32'd1);
    $display("start during load: we_g=%0b addr_g=%03h cnt=%0d", WE_G, ADDR_G, ENTRY_CNT);

    // Saturation: 8193 written entries in total, counter must stop at 8191.
    sat_bad = 0;
    for (int n = 2; n <= 8193; n++) begin
      drive(1'b1, 1'b0, 8'h01, 4'h1, 8'h01, (n == 8193));
      tick();
      exp_cnt = (n > 8191) ? 13'h1FFF : 13'(n);
      if (ENTRY_CNT !== exp_cnt || WE_G !== 1'b1) sat_bad++;
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    chk("sat_stream_errors", 32'(sat_bad), 32'd0);
    chk("sat_entry_cnt", 32'(ENTRY_CNT), 32'd8191);
    tick();
    chk("sat_done", 32'(DONE), 32'd1);
    chk("sat_in_ready", 32'(IN_READY), 32'd0);
    chk("sat_we_g_after", 32'(WE_G), 32'd0);
    $display("saturation: entry_cnt=%0d done=%0b", ENTRY_CNT, DONE);

    // Asynchronous reset when the clear counter reaches 1000.
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_cyc = 0;
    while (ADDR_G !== 12'd1000 && wait_cyc < 2000) begin
      tick();
      wait_cyc++;
    end
    chk("midclear_reached_1000", 32'(ADDR_G), 32'd1000);
    #2 RST = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    RST = 1'b1;
    tick();
    tick();
    check_all_zero("post_rst_idle");
    $display("async reset mid-clear checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/table_writer.md
Name: table_writer

Overview:
- Loader that builds the Aho-Corasick goto and failure tables. It is the write-side counterpart of the table reader.
- On START it first initialises both RAMs: goto entries become FAIL_CODE, except root entries, which become 0. Failure entries become 0.
- It then accepts a valid/ready stream of table entries and turns each one into a single-cycle RAM write.
- It sits between the host/config path and the GOTO_RAM/FAILURE_RAM write ports.

Parameters:
FAIL_CODE, 8'hFF, value written to non-root goto entries during clear; means "no transition".
NUM_STATES, 256, number of legal state IDs; IN_STATE or IN_DATA >= NUM_STATES is an error.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
START  in  1  pulse; begins clear+load when in IDLE or DONE
IN_VALID  in  1  entry valid
IN_READY  out  1  block accepts entry this cycle
IN_TYPE  in  1  0 = goto entry, 1 = failure entry
IN_STATE  in  8  source state
IN_CHARA  in  4  input symbol (goto only; ignored for failure)
IN_DATA  in  8  next state (goto) or failure state (failure)
IN_LAST  in  1  marks final entry of table
WE_G  out  1  goto RAM write enable
ADDR_G  out  12  goto RAM address = {state, chara}
DATA_G  out  8  goto RAM write data
WE_F  out  1  failure RAM write enable
ADDR_F  out  12  failure RAM address = {4'b0000, state}
DATA_F  out  8  failure RAM write data
BUSY  out  1  high in CLEAR and LOAD
DONE  out  1  high in DONE state
ENTRY_CNT  out  13  accepted, valid entries written since START
ERR  out  1  sticky: an out-of-range entry was dropped

Behaviour:
- Reset (RST=0, async): state IDLE. All outputs 0, including IN_READY, WE_*, ADDR_*, DATA_*, BUSY, DONE, ENTRY_CNT and ERR.
- FSM states: IDLE, CLEAR, LOAD, DONE.
  - IDLE --START--> CLEAR.
  - CLEAR --after 4096 writes--> LOAD.
  - LOAD --accepted entry with IN_LAST=1--> DONE.
  - DONE --START--> CLEAR.
  - START is ignored in CLEAR and LOAD.
- Any transition into CLEAR clears ENTRY_CNT and ERR, and resets the 12-bit clear counter c to 0.
- CLEAR, one write per cycle for c = 0..4095 (4096 cycles):
  - Goto write: WE_G=1, ADDR_G=c, DATA_G = 0 if c[11:4]==0 (root state), else FAIL_CODE.
  - Failure write in the same cycle while c < 256: WE_F=1, ADDR_F={4'b0, c[7:0]}, DATA_F=0.
  - IN_READY=0 throughout.
  - Registered outputs: the first write appears the cycle after START is sampled.
- LOAD:
  - IN_READY=1 combinationally while in LOAD; handshake is IN_VALID & IN_READY.
  - Write latency is one cycle: the write strobe and address/data are registered from the accepted entry.
  - Goto entry: WE_G=1, ADDR_G={IN_STATE, IN_CHARA}, DATA_G=IN_DATA.
  - Failure entry: WE_F=1, ADDR_F={4'b0, IN_STATE}, DATA_F=IN_DATA.
  - At most one of WE_G/WE_F is high per cycle.
  - Back-to-back entries are accepted every cycle, giving one write per cycle.
- Range check: if IN_STATE >= NUM_STATES or IN_DATA >= NUM_STATES, the entry is still accepted (it is consumed) but:
  - no write is issued;
  - ENTRY_CNT does not increment;
  - ERR sets and holds until the next START or reset.
- ENTRY_CNT: +1 per written entry; saturates at 8191.
- IN_LAST on an accepted entry:
  - the entry is written (if in range);
  - the FSM goes to DONE on the same edge, and IN_READY=0 from the next cycle.
  - IN_LAST on a dropped entry still ends the load.
- DONE: DONE=1, BUSY=0, IN_READY=0, no writes; ENTRY_CNT and ERR hold.
- WE_G/WE_F are deasserted on any cycle with no write. ADDR/DATA hold their last value when not writing.
- Reset mid-CLEAR or mid-LOAD: immediate return to IDLE with all outputs 0, including the pending write strobe. RAM contents are undefined until the next full START sequence.
- Duplicate entries to the same address: last write wins; no error.

Test Plan:
- Reset, START, count cycles:
  - exactly 4096 goto writes and 256 failure writes;
  - goto addr 0x00F → data 0x00; goto addr 0x010 → 0xFF; failure addr 0x0FF → 0x00;
  - IN_READY rises on cycle 4097 after START.
- LOAD, goto entry state=3, chara=0xA, data=7 → next cycle WE_G=1, ADDR_G=0x03A, DATA_G=0x07, WE_F=0; ENTRY_CNT=1.
- Back-to-back stream: failure (state=5, data=2), then goto (state=5, chara=1, data=9) with IN_LAST on the goto:
  - consecutive writes ADDR_F=0x005/DATA_F=0x02, then ADDR_G=0x051/DATA_G=0x09;
  - DONE=1, ENTRY_CNT=2, IN_READY=0 afterwards.
- NUM_STATES=16, entry state=20 → no write, ERR=1, ENTRY_CNT unchanged; subsequent valid entry written normally, ERR stays 1.
- START pulsed during CLEAR and during LOAD → ignored (clear count still 4096, LOAD continues); START in DONE → restarts CLEAR, ERR and ENTRY_CNT cleared.
- Assert RST low at clear counter 1000 → all outputs 0 asynchronously; after release, IDLE with IN_READY=0 until START.
